wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter sitting directly upstream of the scalar register file. It collects destination-register results from up to NUM_SRC execution sources over valid/ready handshakes and buffers each source in a 2-entry FIFO. Every cycle it grants up to three results round-robin and drives them from registers onto the register file's three write ports. Writes to x0 are discarded at entry, so x0 never occupies a FIFO slot or a write port.

## Interface
Parameters:
- DATA_WIDTH, 32, result width
- ADDR_WIDTH, 6, destination register index width
- NUM_SRC, 4, number of result sources (2..8)
- READ_PORTS, 2, forwarding lookup ports (used only with WB_FWD_EN)

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n`, asynchronous, active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_valid  in  [NUM_SRC]  source has a result
- src_ready  out  [NUM_SRC]  source FIFO can accept
- src_addr  in  [NUM_SRC][ADDR_WIDTH]  destination register
- src_data  in  [NUM_SRC][DATA_WIDTH]  result value
- write_En / write_Addr / write_Data  out  1/ADDR_WIDTH/DATA_WIDTH  register file write port 1
- write_En_2 / write_Addr_2 / write_Data_2  out  same widths  write port 2
- write_En_3 / write_Addr_3 / write_Data_3  out  same widths  write port 3
- fwd_Addr  in  [READ_PORTS][ADDR_WIDTH]  lookup address (WB_FWD_EN only)
- fwd_Hit  out  [READ_PORTS]  in-flight write matches (WB_FWD_EN only)
- fwd_Data  out  [READ_PORTS][DATA_WIDTH]  in-flight value (WB_FWD_EN only)

## Operation
- Each source has a 2-entry FIFO.
  - src_ready[i] = (count[i] < 2), computed from the registered count only.
  - A full FIFO does not accept a push in the same cycle as a pop.
- Acceptance happens on valid & ready.
  - If src_addr is 0, the result is accepted and dropped: nothing is enqueued and no write is issued.
- Arbitration, each cycle:
  - Scan the non-empty FIFO heads starting at rr_ptr, wrapping modulo NUM_SRC.
  - Grant at most 3 heads. Grants fill ports in order: first grant to port 1, second to port 2, third to port 3.
  - Granted heads pop.
- rr_ptr update:
  - Advances to (last granted source + 1) mod NUM_SRC.
  - Holds when nothing is granted.
- Same-address rule: if a candidate head has the same address as an already-granted head in the same cycle, it is skipped and retried in a later cycle. Port contents are therefore always address-distinct.
- Output registers load the granted entries. Ports with no grant load En = 0; their Addr and Data hold their previous values.
- Cross-source ordering to the same register is the issue logic's responsibility. Within one source, results are written in FIFO order.

## Timing
- Reset: all write_En*, write_Addr*, write_Data*, FIFO counts, rr_ptr and fwd_Hit are 0. src_ready is all 1 once reset is released.
- Latency:
  - A result accepted in cycle C sits at the FIFO head in C+1.
  - It is at the earliest granted in C+1 and presented on a write port in C+2.
  - The register file captures it at the end of C+2.
- Throughput is 3 writes per cycle peak and 1 accept per source per cycle. With no pop, a source FIFO fills after 2 accepts.
- Reset asserted mid-operation clears FIFO contents and outputs immediately. Pending results are lost.

## Configuration
- WB_FWD_EN defined:
  - The fwd_* ports exist.
  - fwd_Hit[k] = 1 when a write port currently has En = 1 and Addr equal to a nonzero fwd_Addr[k]. fwd_Data[k] is that port's data.
  - The logic is combinational from the output registers. Ports are address-distinct, so at most one port matches.
  - When fwd_Hit[k] = 0, fwd_Data[k] is 0.
- WB_FWD_EN undefined: the fwd_* ports and their logic are absent. Consumers read the register file one cycle later.

## Structure
- Package wb_pkg holds:
  - typedef wb_req_t {addr, data}
  - constant NUM_WB_PORTS = 3
  - the default DATA_WIDTH and ADDR_WIDTH values
- Sub-module wb_fifo: a 2-entry FIFO of wb_req_t with push, pop, full, empty and head. It is instantiated NUM_SRC times.
- The top level contains the round-robin grant, the same-address filter and the output registers.

## Test plan
- Single result (src 0, addr 5, data 0xDEADBEEF) accepted in cycle 1 -> cycle 3 shows write_En = 1, write_Addr = 5, write_Data = 0xDEADBEEF, other enables 0.
- x0 write (src 1, addr 0): src_ready stays 1 and no write_En* asserts in any later cycle.
- All 4 sources valid every cycle with distinct addresses 1..4, rr_ptr starting at 0:
  - cycle 2 grants sources 0,1,2;
  - cycle 3 grants 3,0,1;
  - no source starves.
- Sources 0 and 2 both target addr 7 in the same cycle -> the write to 7 from source 0 appears on the ports first, source 2's the next cycle; never both in one cycle.
- Hold source 3 valid with no grants while it fills -> src_ready[3] drops after 2 accepts and recovers the cycle after a pop.
- With WB_FWD_EN defined: while write_En_2 = 1, write_Addr_2 = 9, write_Data_2 = 0x55, fwd_Addr[0] = 9 -> fwd_Hit[0] = 1 and fwd_Data[0] = 0x55. fwd_Addr[0] = 0 -> fwd_Hit[0] = 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 6;
  localparam int unsigned NUM_WB_PORTS       = 3;

  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry FIFO holding pending writeback requests for one source.
module wb_fifo
  import wb_pkg::*;
#(
  parameter type T = wb_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     push_data,
  output logic full,
  output logic empty,
  output T     head
);

  T           mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  // Push is gated on the registered full flag, so a full FIFO never takes
  // a push in the same cycle it pops.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs, 3-wide round-robin grant with a
// same-address filter, registered register-file write ports.
// Optional feature macro: WB_FWD_EN (forwarding lookup ports).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned READ_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0]                   src_valid,
  output logic [NUM_SRC-1:0]                   src_ready,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   src_addr,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data,
  output logic                                 write_En,
  output logic [ADDR_WIDTH-1:0]                write_Addr,
  output logic [DATA_WIDTH-1:0]                write_Data,
  output logic                                 write_En_2,
  output logic [ADDR_WIDTH-1:0]                write_Addr_2,
  output logic [DATA_WIDTH-1:0]                write_Data_2,
  output logic                                 write_En_3,
  output logic [ADDR_WIDTH-1:0]                write_Addr_3,
  output logic [DATA_WIDTH-1:0]                write_Data_3
`ifdef WB_FWD_EN
  ,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] fwd_Addr,
  output logic [READ_PORTS-1:0]                 fwd_Hit,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] fwd_Data
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t               in_req   [NUM_SRC];
  req_t               head     [NUM_SRC];
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_next;

  logic               g_en     [NUM_WB_PORTS];
  req_t               g_req    [NUM_WB_PORTS];
  logic               out_en   [NUM_WB_PORTS];
  req_t               out_req  [NUM_WB_PORTS];

  assign src_ready = ~full;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // x0 results complete the handshake but are never enqueued.
    assign in_req[i] = '{addr: src_addr[i], data: src_data[i]};
    assign push[i]   = src_valid[i] & ~full[i] & (src_addr[i] != '0);

    wb_fifo #(
      .T (req_t)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .pop       (pop[i]),
      .push_data (in_req[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (head[i])
    );
  end

  // Round-robin scan from rr_ptr; grants fill ports in order, skipping any
  // head whose address is already granted this cycle.
  always_comb begin
    logic [1:0]       n_grant;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] last_idx;
    logic             any;
    logic             conflict;
    int unsigned      idx_i;

    pop      = '0;
    n_grant  = '0;
    idx      = '0;
    last_idx = rr_ptr;
    any      = 1'b0;
    conflict = 1'b0;
    idx_i    = 0;
    for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
      g_en[p]  = 1'b0;
      g_req[p] = '0;
    end

    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx_i = k + 32'(rr_ptr);
      if (idx_i >= NUM_SRC) begin
        idx_i = idx_i - NUM_SRC;
      end
      idx = PTR_W'(idx_i);

      conflict = 1'b0;
      for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
        if (g_en[p] && (g_req[p].addr == head[idx].addr)) begin
          conflict = 1'b1;
        end
      end

      if (!empty[idx] && !conflict && (n_grant < 2'(NUM_WB_PORTS))) begin
        pop[idx]       = 1'b1;
        g_en[n_grant]  = 1'b1;
        g_req[n_grant] = head[idx];
        n_grant        = n_grant + 2'd1;
        last_idx       = idx;
        any            = 1'b1;
      end
    end

    if (!any) begin
      rr_next = rr_ptr;
    end else if (32'(last_idx) + 1 >= NUM_SRC) begin
      rr_next = '0;
    end else begin
      rr_next = last_idx + PTR_W'(1);
    end
  end

  // Output registers and round-robin pointer; ungranted ports keep addr/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
        out_en[p]  <= 1'b0;
        out_req[p] <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
        out_en[p] <= g_en[p];
        if (g_en[p]) begin
          out_req[p] <= g_req[p];
        end
      end
    end
  end

  assign write_En     = out_en[0];
  assign write_Addr   = out_req[0].addr;
  assign write_Data   = out_req[0].data;
  assign write_En_2   = out_en[1];
  assign write_Addr_2 = out_req[1].addr;
  assign write_Data_2 = out_req[1].data;
  assign write_En_3   = out_en[2];
  assign write_Addr_3 = out_req[2].addr;
  assign write_Data_3 = out_req[2].data;

`ifdef WB_FWD_EN
  // Ports are address-distinct, so at most one port can match a lookup.
  always_comb begin
    fwd_Hit  = '0;
    fwd_Data = '0;
    for (int unsigned k = 0; k < READ_PORTS; k++) begin
      for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
        if (out_en[p] && (fwd_Addr[k] != '0) && (out_req[p].addr == fwd_Addr[k])) begin
          fwd_Hit[k]  = 1'b1;
          fwd_Data[k] = out_req[p].data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (forwarding checks under WB_FWD_EN).
module tb_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned NS = 4;
  localparam int unsigned RP = 2;

  logic                   clk;
  logic                   rst_n;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0]          src_ready;
  logic [NS-1:0][AW-1:0]  src_addr;
  logic [NS-1:0][DW-1:0]  src_data;
  logic                   write_En, write_En_2, write_En_3;
  logic [AW-1:0]          write_Addr, write_Addr_2, write_Addr_3;
  logic [DW-1:0]          write_Data, write_Data_2, write_Data_3;
`ifdef WB_FWD_EN
  logic [RP-1:0][AW-1:0]  fwd_Addr;
  logic [RP-1:0]          fwd_Hit;
  logic [RP-1:0][DW-1:0]  fwd_Data;
`endif

  int unsigned pass_cnt;
  int unsigned total_cnt;

  logic [AW+DW:0] p1, p2, p3;
  logic [2:0]     ens;
  assign p1  = {write_En, write_Addr, write_Data};
  assign p2  = {write_En_2, write_Addr_2, write_Data_2};
  assign p3  = {write_En_3, write_Addr_3, write_Data_3};
  assign ens = {write_En_3, write_En_2, write_En};

  wb_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_SRC    (NS),
    .READ_PORTS (RP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_addr     (src_addr),
    .src_data     (src_data),
    .write_En     (write_En),
    .write_Addr   (write_Addr),
    .write_Data   (write_Data),
    .write_En_2   (write_En_2),
    .write_Addr_2 (write_Addr_2),
    .write_Data_2 (write_Data_2),
    .write_En_3   (write_En_3),
    .write_Addr_3 (write_Addr_3),
    .write_Data_3 (write_Data_3)
`ifdef WB_FWD_EN
    ,
    .fwd_Addr     (fwd_Addr),
    .fwd_Hit      (fwd_Hit),
    .fwd_Data     (fwd_Data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW+DW:0] pv(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {en, a, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    #12;
    total_cnt++;
    if (p1 !== '0) $display("FAIL reset_port1: got %h expected 0", p1); else pass_cnt++;
    total_cnt++;
    if ({p2, p3} !== '0) $display("FAIL reset_port23: got %h %h expected 0", p2, p3); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (src_ready !== 4'hF) $display("FAIL reset_ready: got %b expected 1111", src_ready); else pass_cnt++;
    total_cnt++;
    if (ens !== 3'b000) $display("FAIL reset_en: got %b expected 000", ens); else pass_cnt++;
`ifdef WB_FWD_EN
    total_cnt++;
    if (fwd_Hit !== '0) $display("FAIL reset_fwd_hit: got %b expected 00", fwd_Hit); else pass_cnt++;
`endif
  endtask

  task automatic test_single;
    src_valid[0] = 1'b1;
    src_addr[0]  = 6'd5;
    src_data[0]  = 32'hDEADBEEF;
    tick();
    clear_inputs();
    total_cnt++;
    if (ens !== 3'b000) $display("FAIL single_early: got %b expected 000", ens); else pass_cnt++;
    tick();
    total_cnt++;
    if (p1 !== pv(1'b1, 6'd5, 32'hDEADBEEF)) $display("FAIL single_port1: got %h expected %h", p1, pv(1'b1, 6'd5, 32'hDEADBEEF)); else pass_cnt++;
    total_cnt++;
    if ({write_En_2, write_En_3} !== 2'b00) $display("FAIL single_other_en: got %b expected 00", {write_En_2, write_En_3}); else pass_cnt++;
    tick();
    total_cnt++;
    if (p1 !== pv(1'b0, 6'd5, 32'hDEADBEEF)) $display("FAIL single_hold: got %h expected %h", p1, pv(1'b0, 6'd5, 32'hDEADBEEF)); else pass_cnt++;
  endtask

  task automatic test_x0;
    src_valid[1] = 1'b1;
    src_addr[1]  = 6'd0;
    src_data[1]  = 32'h1234;
    total_cnt++;
    if (src_ready[1] !== 1'b1) $display("FAIL x0_ready_pre: got %b expected 1", src_ready[1]); else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (src_ready[1] !== 1'b1) $display("FAIL x0_ready_post: got %b expected 1", src_ready[1]); else pass_cnt++;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (ens !== 3'b000) $display("FAIL x0_no_write: cycle %0d got %b expected 000", i, ens); else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (p1 !== pv(1'b0, 6'd5, 32'hDEADBEEF)) $display("FAIL x0_port1_hold: got %h expected %h", p1, pv(1'b0, 6'd5, 32'hDEADBEEF)); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic [AW-1:0]  exp_a [4][3];
    logic [AW+DW:0] obs;
    logic [AW-1:0]  a;
    int unsigned    wcnt [NS];
    exp_a = '{'{6'd1, 6'd2, 6'd3}, '{6'd4, 6'd1, 6'd2}, '{6'd3, 6'd4, 6'd1}, '{6'd2, 6'd3, 6'd4}};
    for (int i = 0; i < NS; i++) wcnt[i] = 0;
    do_reset();
    for (int i = 0; i < NS; i++) begin
      src_valid[i] = 1'b1;
      src_addr[i]  = AW'(i + 1);
      src_data[i]  = 32'hA0 + 32'(i);
    end
    tick();
    for (int n = 0; n < 8; n++) begin
      tick();
      for (int p = 0; p < 3; p++) begin
        case (p)
          0:       obs = p1;
          1:       obs = p2;
          default: obs = p3;
        endcase
        a = exp_a[n % 4][p];
        total_cnt++;
        if (obs !== pv(1'b1, a, 32'hA0 + 32'(a) - 32'd1))
          $display("FAIL rr_port%0d_cycle%0d: got %h expected %h", p + 1, n, obs, pv(1'b1, a, 32'hA0 + 32'(a) - 32'd1));
        else
          pass_cnt++;
        if (obs[AW+DW] && obs[AW+DW-1:DW] >= 6'd1 && obs[AW+DW-1:DW] <= 6'd4)
          wcnt[obs[AW+DW-1:DW] - 6'd1]++;
      end
    end
    clear_inputs();
    for (int i = 0; i < NS; i++) begin
      total_cnt++;
      if (wcnt[i] !== 6) $display("FAIL rr_fairness_src%0d: got %0d writes expected 6", i, wcnt[i]); else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_same_addr;
    do_reset();
    src_valid   = 4'hF;
    src_addr[0] = 6'd7; src_data[0] = 32'h70;
    src_addr[1] = 6'd8; src_data[1] = 32'h81;
    src_addr[2] = 6'd7; src_data[2] = 32'h72;
    src_addr[3] = 6'd9; src_data[3] = 32'h93;
    tick();
    clear_inputs();
    tick();
    total_cnt++;
    if (p1 !== pv(1'b1, 6'd7, 32'h70)) $display("FAIL same_c1_port1: got %h expected %h", p1, pv(1'b1, 6'd7, 32'h70)); else pass_cnt++;
    total_cnt++;
    if (p2 !== pv(1'b1, 6'd8, 32'h81)) $display("FAIL same_c1_port2: got %h expected %h", p2, pv(1'b1, 6'd8, 32'h81)); else pass_cnt++;
    total_cnt++;
    if (p3 !== pv(1'b1, 6'd9, 32'h93)) $display("FAIL same_c1_port3: got %h expected %h", p3, pv(1'b1, 6'd9, 32'h93)); else pass_cnt++;
    tick();
    total_cnt++;
    if (p1 !== pv(1'b1, 6'd7, 32'h72)) $display("FAIL same_c2_port1: got %h expected %h", p1, pv(1'b1, 6'd7, 32'h72)); else pass_cnt++;
    total_cnt++;
    if ({write_En_2, write_En_3} !== 2'b00) $display("FAIL same_c2_other_en: got %b expected 00", {write_En_2, write_En_3}); else pass_cnt++;
    tick();
    total_cnt++;
    if (ens !== 3'b000) $display("FAIL same_c3_idle: got %b expected 000", ens); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] exp_d [5];
    logic          exp_r [5];
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h31, 32'h32};
    exp_r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    src_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      src_addr[i] = 6'd10;
      src_data[i] = 32'h10 + 32'(i);
    end
    src_addr[3] = 6'd10;
    src_data[3] = 32'h31;
    tick();
    src_valid[2:0] = 3'b000;
    src_data[3]    = 32'h32;
    total_cnt++;
    if (src_ready[3] !== 1'b1) $display("FAIL bp_ready_one: got %b expected 1", src_ready[3]); else pass_cnt++;
    for (int n = 0; n < 5; n++) begin
      tick();
      src_data[3] = 32'h33 + 32'(n);
      total_cnt++;
      if (src_ready[3] !== exp_r[n]) $display("FAIL bp_ready_c%0d: got %b expected %b", n, src_ready[3], exp_r[n]); else pass_cnt++;
      total_cnt++;
      if (p1 !== pv(1'b1, 6'd10, exp_d[n])) $display("FAIL bp_port1_c%0d: got %h expected %h", n, p1, pv(1'b1, 6'd10, exp_d[n])); else pass_cnt++;
      total_cnt++;
      if ({write_En_2, write_En_3} !== 2'b00) $display("FAIL bp_other_en_c%0d: got %b expected 00", n, {write_En_2, write_En_3}); else pass_cnt++;
    end
    clear_inputs();
    tick();
    total_cnt++;
    if (p1 !== pv(1'b1, 6'd10, 32'h36)) $display("FAIL bp_last: got %h expected %h", p1, pv(1'b1, 6'd10, 32'h36)); else pass_cnt++;
    tick();
    total_cnt++;
    if (ens !== 3'b000) $display("FAIL bp_idle: got %b expected 000", ens); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    src_valid   = 4'b0011;
    src_addr[0] = 6'd5; src_data[0] = 32'h501;
    src_addr[1] = 6'd5; src_data[1] = 32'h502;
    tick();
    clear_inputs();
    tick();
    total_cnt++;
    if (p1 !== pv(1'b1, 6'd5, 32'h501)) $display("FAIL rmid_before: got %h expected %h", p1, pv(1'b1, 6'd5, 32'h501)); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({p1, p2, p3} !== '0) $display("FAIL rmid_async_clear: got %h %h %h expected 0", p1, p2, p3); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (ens !== 3'b000) $display("FAIL rmid_lost_c%0d: got %b expected 000", i, ens); else pass_cnt++;
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_forwarding;
    do_reset();
    src_valid   = 4'b0011;
    src_addr[0] = 6'd8; src_data[0] = 32'h11;
    src_addr[1] = 6'd9; src_data[1] = 32'h55;
    tick();
    clear_inputs();
    tick();
    total_cnt++;
    if (p2 !== pv(1'b1, 6'd9, 32'h55)) $display("FAIL fwd_port2: got %h expected %h", p2, pv(1'b1, 6'd9, 32'h55)); else pass_cnt++;
    fwd_Addr[0] = 6'd9;
    fwd_Addr[1] = 6'd8;
    #1;
    total_cnt++;
    if (fwd_Hit !== 2'b11) $display("FAIL fwd_hit: got %b expected 11", fwd_Hit); else pass_cnt++;
    total_cnt++;
    if (fwd_Data[0] !== 32'h55) $display("FAIL fwd_data0: got %h expected 00000055", fwd_Data[0]); else pass_cnt++;
    total_cnt++;
    if (fwd_Data[1] !== 32'h11) $display("FAIL fwd_data1: got %h expected 00000011", fwd_Data[1]); else pass_cnt++;
    fwd_Addr[0] = 6'd0;
    fwd_Addr[1] = 6'd12;
    #1;
    total_cnt++;
    if (fwd_Hit !== 2'b00) $display("FAIL fwd_miss: got %b expected 00", fwd_Hit); else pass_cnt++;
    total_cnt++;
    if (fwd_Data !== '0) $display("FAIL fwd_miss_data: got %h expected 0", fwd_Data); else pass_cnt++;
    fwd_Addr = '0;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    clear_inputs();
`ifdef WB_FWD_EN
    fwd_Addr = '0;
`endif
    test_reset();
    test_single();
    test_x0();
    test_round_robin();
    test_same_addr();
    test_backpressure();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_forwarding();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
